// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/PWM/ONESHOT on a shared prescaled tick.
// Optional LED_PATTERN_SHADOW_EN buffers PWM duty/period writes until the channel's next phase wrap.
module led_pattern_ctrl #(
  parameter int NR_CHANNELS = 3,
  parameter int PRESCALE    = 1000000,
  parameter int PERIOD_BITS = 8,
  parameter int ADDR_BITS   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_wr,
  input  logic                       cfg_rd,
  input  logic [ADDR_BITS-1:0]       cfg_addr,
  input  logic [2*PERIOD_BITS+1:0]   cfg_wdata,
  output logic [2*PERIOD_BITS+1:0]   cfg_rdata,
  output logic                       cfg_rvalid,
  input  logic                       restart,
  output logic                       tick,
  output logic [NR_CHANNELS-1:0]     led_out,
  output logic [NR_CHANNELS-1:0]     led_oe,
  output logic [NR_CHANNELS-1:0]     oneshot_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam int CFG_W = 2 + 2 * PERIOD_BITS;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  mode_e                  mode_q   [NR_CHANNELS];
  mode_e                  mode_d   [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] duty_q   [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] duty_d   [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] period_q [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] period_d [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] phase_q  [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] phase_d  [NR_CHANNELS];
`ifdef LED_PATTERN_SHADOW_EN
  logic [PERIOD_BITS-1:0] sduty_q   [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] sduty_d   [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] speriod_q [NR_CHANNELS];
  logic [PERIOD_BITS-1:0] speriod_d [NR_CHANNELS];
  logic [NR_CHANNELS-1:0] pend_q, pend_d;
`endif
  logic [NR_CHANNELS-1:0] out_q, out_d, oe_q, oe_d, done_q, done_d;
  logic [NR_CHANNELS-1:0] wr_hit, wrap;
  logic [CFG_W-1:0]       rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  mode_e                  wr_mode;
  logic [PERIOD_BITS-1:0] wr_duty, wr_period;

  assign wr_mode   = mode_e'(cfg_wdata[1:0]);
  assign wr_duty   = cfg_wdata[PERIOD_BITS+1:2];
  assign wr_period = cfg_wdata[2*PERIOD_BITS+1:PERIOD_BITS+2];

  // restart suppresses both the tick pulse and any phase advance, so a shot restarts cleanly
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    wr_hit = '0;
    wrap   = '0;
    for (int i = 0; i < NR_CHANNELS; i++) begin
      wr_hit[i] = cfg_wr && (cfg_addr == ADDR_BITS'(i));
      wrap[i]   = tick_q && !restart && (phase_q[i] == period_q[i]);
    end
  end

  always_comb begin
    out_d  = '0;
    oe_d   = '0;
    done_d = '0;
`ifdef LED_PATTERN_SHADOW_EN
    pend_d = pend_q;
`endif
    for (int i = 0; i < NR_CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      duty_d[i]   = duty_q[i];
      period_d[i] = period_q[i];
      phase_d[i]  = phase_q[i];
`ifdef LED_PATTERN_SHADOW_EN
      sduty_d[i]   = sduty_q[i];
      speriod_d[i] = speriod_q[i];
`endif
      if (tick_q && !restart)
        phase_d[i] = wrap[i] ? '0 : phase_q[i] + 1'b1;
      if (wrap[i] && mode_q[i] == MODE_ONESHOT && !wr_hit[i]) begin
        mode_d[i] = MODE_OFF;
        done_d[i] = 1'b1;
      end
`ifdef LED_PATTERN_SHADOW_EN
      if (wrap[i] && pend_q[i]) begin
        duty_d[i]   = sduty_q[i];
        period_d[i] = speriod_q[i];
        pend_d[i]   = 1'b0;
      end
`endif
      if (restart)
        phase_d[i] = '0;
      if (wr_hit[i]) begin
`ifdef LED_PATTERN_SHADOW_EN
        if (mode_q[i] == MODE_PWM) begin
          mode_d[i]    = wr_mode;
          sduty_d[i]   = wr_duty;
          speriod_d[i] = wr_period;
          pend_d[i]    = 1'b1;
        end else begin
          mode_d[i]   = wr_mode;
          duty_d[i]   = wr_duty;
          period_d[i] = wr_period;
          phase_d[i]  = '0;
          pend_d[i]   = 1'b0;
        end
`else
        mode_d[i]   = wr_mode;
        duty_d[i]   = wr_duty;
        period_d[i] = wr_period;
        phase_d[i]  = '0;
`endif
      end
      case (mode_q[i])
        MODE_ON: begin
          oe_d[i]  = 1'b1;
          out_d[i] = 1'b1;
        end
        MODE_PWM, MODE_ONESHOT: begin
          oe_d[i]  = 1'b1;
          out_d[i] = (phase_q[i] < duty_q[i]);
        end
        default: ;
      endcase
    end
  end

  // Read handshake: cfg_rd is a one-cycle request with no backpressure; cfg_rvalid pulses
  // exactly one cycle later alongside cfg_rdata, which then holds until the next read.
  always_comb begin
    rvalid_d = cfg_rd;
    rdata_d  = rdata_q;
    if (cfg_rd) begin
      rdata_d = '0;
      for (int i = 0; i < NR_CHANNELS; i++)
        if (cfg_addr == ADDR_BITS'(i))
          rdata_d = {phase_q[i], duty_q[i], mode_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      out_q    <= '0;
      oe_q     <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        duty_q[i]   <= '0;
        period_q[i] <= '0;
        phase_q[i]  <= '0;
`ifdef LED_PATTERN_SHADOW_EN
        sduty_q[i]   <= '0;
        speriod_q[i] <= '0;
`endif
      end
`ifdef LED_PATTERN_SHADOW_EN
      pend_q <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NR_CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        duty_q[i]   <= duty_d[i];
        period_q[i] <= period_d[i];
        phase_q[i]  <= phase_d[i];
`ifdef LED_PATTERN_SHADOW_EN
        sduty_q[i]   <= sduty_d[i];
        speriod_q[i] <= speriod_d[i];
`endif
      end
`ifdef LED_PATTERN_SHADOW_EN
      pend_q <= pend_d;
`endif
    end
  end

  assign tick         = tick_q;
  assign led_out      = out_q;
  assign led_oe       = oe_q;
  assign oneshot_done = done_q;
  assign cfg_rdata    = rdata_q;
  assign cfg_rvalid   = rvalid_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: tick-count reference model feeds expected queues, a negedge monitor compares.
module tb_led_pattern_ctrl;

  localparam int N  = 3;
  localparam int P  = 4;
  localparam int PB = 8;
  localparam int AB = 4;
  localparam int CW = 2 + 2 * PB;
  localparam int EW = 1 + 3 * N;

  logic          clk;
  logic          reset;
  logic          cfg_wr;
  logic          cfg_rd;
  logic [AB-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic [CW-1:0] cfg_rdata;
  logic          cfg_rvalid;
  logic          restart;
  logic          tick;
  logic [N-1:0]  led_out;
  logic [N-1:0]  led_oe;
  logic [N-1:0]  oneshot_done;

  led_pattern_ctrl #(
    .NR_CHANNELS(N),
    .PRESCALE   (P),
    .PERIOD_BITS(PB),
    .ADDR_BITS  (AB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_wr      (cfg_wr),
    .cfg_rd      (cfg_rd),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .cfg_rvalid  (cfg_rvalid),
    .restart     (restart),
    .tick        (tick),
    .led_out     (led_out),
    .led_oe      (led_oe),
    .oneshot_done(oneshot_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Time is "cycles since reset/restart"; a channel's phase is the number of ticks it
  // has consumed since its last write/restart, taken modulo (period + 1).
  int m_mode [N];
  int m_duty [N];
  int m_per  [N];
  int m_cnt  [N];
  int m_sduty[N];
  int m_sper [N];
  bit m_pend [N];
  int cyc;

  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] exp_rd_q[$];
  int checks;
  int errors;

  function automatic int phase_of(input int ch);
    return m_cnt[ch] % (m_per[ch] + 1);
  endfunction

  function automatic logic [CW-1:0] mk(input int per, input int duty, input int mode);
    logic [PB-1:0] p;
    logic [PB-1:0] d;
    logic [1:0]    m;
    p = PB'(per);
    d = PB'(duty);
    m = 2'(mode);
    return {p, d, m};
  endfunction

  task automatic model_step();
    logic [N-1:0]  e_out;
    logic [N-1:0]  e_oe;
    logic [N-1:0]  e_done;
    logic          e_tick;
    logic [CW-1:0] rd;
    bit            tick_pre;
    int            a;
    int            ph;
    e_out  = '0;
    e_oe   = '0;
    e_done = '0;
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_mode[c] = 0; m_duty[c] = 0; m_per[c] = 0; m_cnt[c] = 0;
        m_sduty[c] = 0; m_sper[c] = 0; m_pend[c] = 0;
      end
      cyc = 0;
      exp_q.push_back('0);
      return;
    end
    for (int c = 0; c < N; c++) begin
      ph = phase_of(c);
      if (m_mode[c] == 1) begin
        e_oe[c] = 1'b1; e_out[c] = 1'b1;
      end else if (m_mode[c] >= 2) begin
        e_oe[c] = 1'b1; e_out[c] = (ph < m_duty[c]);
      end
    end
    a = int'(cfg_addr);
    if (cfg_rd) begin
      rd = '0;
      if (a < N) rd = {PB'(phase_of(a)), PB'(m_duty[a]), 2'(m_mode[a])};
      exp_rd_q.push_back(rd);
    end
    tick_pre = (cyc > 0) && (cyc % P == 0);
    if (tick_pre && !restart) begin
      for (int c = 0; c < N; c++) begin
        bit w;
        w = (phase_of(c) == m_per[c]);
        m_cnt[c]++;
        if (w && m_mode[c] == 3) begin
          m_mode[c] = 0;
          e_done[c] = 1'b1;
        end
        if (w && m_pend[c]) begin
          m_duty[c] = m_sduty[c];
          m_per[c]  = m_sper[c];
          m_pend[c] = 0;
          m_cnt[c]  = 0;
        end
      end
    end
    if (restart)
      for (int c = 0; c < N; c++) m_cnt[c] = 0;
    if (cfg_wr && a < N) begin
      e_done[a] = 1'b0;
`ifdef LED_PATTERN_SHADOW_EN
      if (m_mode[a] == 2) begin
        m_mode[a]  = int'(cfg_wdata[1:0]);
        m_sduty[a] = int'(cfg_wdata[PB+1:2]);
        m_sper[a]  = int'(cfg_wdata[2*PB+1:PB+2]);
        m_pend[a]  = 1;
      end else begin
        m_mode[a] = int'(cfg_wdata[1:0]);
        m_duty[a] = int'(cfg_wdata[PB+1:2]);
        m_per[a]  = int'(cfg_wdata[2*PB+1:PB+2]);
        m_cnt[a]  = 0;
        m_pend[a] = 0;
      end
`else
      m_mode[a] = int'(cfg_wdata[1:0]);
      m_duty[a] = int'(cfg_wdata[PB+1:2]);
      m_per[a]  = int'(cfg_wdata[2*PB+1:PB+2]);
      m_cnt[a]  = 0;
`endif
    end
    cyc    = restart ? 0 : cyc + 1;
    e_tick = (cyc > 0) && (cyc % P == 0);
    exp_q.push_back({e_tick, e_done, e_oe, e_out});
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [CW-1:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({tick, oneshot_done, led_oe, led_out} !== e) begin
        errors++;
        $display("FAIL led_state t=%0t got tick=%b done=%b oe=%b out=%b exp tick=%b done=%b oe=%b out=%b",
                 $time, tick, oneshot_done, led_oe, led_out,
                 e[EW-1], e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
      end
    end
    if (cfg_rvalid) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected t=%0t got rvalid=1 exp rvalid=0", $time);
      end else begin
        r = exp_rd_q.pop_front();
        if (cfg_rdata !== r) begin
          errors++;
          $display("FAIL readback t=%0t got=%h exp=%h", $time, cfg_rdata, r);
        end
      end
    end else if (exp_rd_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL rvalid_missing t=%0t got rvalid=0 exp rvalid=1", $time);
      exp_rd_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic wr, input logic rd, input int a, input logic [CW-1:0] wd,
                       input logic rs, input logic rst);
    cfg_wr    = wr;
    cfg_rd    = rd;
    cfg_addr  = AB'(a);
    cfg_wdata = wd;
    restart   = rs;
    reset     = rst;
    @(negedge clk);
    cfg_wr  = 1'b0;
    cfg_rd  = 1'b0;
    restart = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic wr_ch(input int a, input int per, input int duty, input int mode);
    drive(1'b1, 1'b0, a, mk(per, duty, mode), 1'b0, 1'b0);
  endtask

  task automatic rd_ch(input int a);
    drive(1'b0, 1'b1, a, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_phase(input int ch, input int ph);
    for (int k = 0; k < 64 && phase_of(ch) != ph; k++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    cfg_wr    = 1'b0;
    cfg_rd    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    restart   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(12);

    wr_ch(0, 3, 2, 2);
    idle(40);
    wr_ch(1, 3, 0, 2);
    idle(20);
    wr_ch(1, 3, 5, 2);
    idle(20);
    wr_ch(2, 2, 1, 3);
    idle(20);
    rd_ch(2);
    idle(2);

    wait_phase(0, 2);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
    rd_ch(0);
    idle(10);

    wr_ch(N, 5, 5, 1);
    rd_ch(N);
    wr_ch(15, 1, 1, 1);
    rd_ch(15);
    drive(1'b1, 1'b1, 1, mk(2, 1, 1), 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 2, mk(1, 1, 3), 1'b1, 1'b0);
    idle(20);

    wr_ch(0, 3, 1, 2);
    idle(6);
    wait_phase(0, 1);
    wr_ch(0, 3, 3, 2);
    idle(30);
    rd_ch(0);
    idle(4);

    for (int k = 0; k < 1500; k++) begin
      logic wr;
      logic rd;
      logic rs;
      logic rst;
      int   a;
      wr  = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      rs  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      a   = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, N + 1));
      drive(wr, rd, a, mk($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 3)), rs, rst);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Multi-channel LED pattern generator. It is the parametrised successor of the fixed free-running LED blink counter. Each channel has its own mode, period and duty, configured through a simple register write/read port; that port is driven by the JTAG-side register logic after it has been synchronised into the clk domain. Outputs are value/enable pairs, so pins can tri-state in the same style as the JTAG GPIO block.

Parameters:
NR_CHANNELS, 3, number of independent LED channels (1..16)
PRESCALE, 1000000, clk cycles per tick (>=2)
PERIOD_BITS, 8, width of the per-channel period, duty and phase registers
ADDR_BITS, 4, width of the channel address (2^ADDR_BITS >= NR_CHANNELS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_wr  in  1  single-cycle write strobe
cfg_rd  in  1  single-cycle read strobe
cfg_addr  in  ADDR_BITS  channel index
cfg_wdata  in  2+2*PERIOD_BITS  {period, duty, mode[1:0]}; mode in bits [1:0], duty next, period MSBs
cfg_rdata  out  2+2*PERIOD_BITS  readback {phase, duty, mode}
cfg_rvalid  out  1  readback valid, one-cycle pulse
restart  in  1  synchronous restart of all timing (e.g. debounced button)
tick  out  1  one-cycle pulse per prescaler wrap
led_out  out  NR_CHANNELS  LED value
led_oe  out  NR_CHANNELS  LED output enable
oneshot_done  out  NR_CHANNELS  one-cycle pulse when a one-shot completes

Behaviour:
- Reset: all mode/duty/period/phase registers = 0; prescaler = 0; all outputs 0.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick is registered and asserts for the one cycle after the count wraps.
  - restart clears the prescaler to 0 with no tick.
- Channel phase:
  - On each tick, phase = (phase == period) ? 0 : phase+1.
  - One pattern cycle is therefore period+1 ticks.
  - period = 0 holds phase at 0.
- Modes:
  - 0 OFF: oe=0, out=0.
  - 1 ON: oe=1, out=1.
  - 2 PWM: oe=1, out = (phase < duty).
    - duty=0 gives constantly low.
    - duty > period gives constantly high.
  - 3 ONESHOT: oe=1, out = (phase < duty).
    - When a tick arrives with phase == period, mode becomes 0 and oneshot_done[ch] pulses for 1 cycle.
    - The next cycle's outputs follow OFF.
- Outputs: led_out and led_oe are registered, so they reflect channel state one cycle after the state changes.
- Write:
  - cfg_wr with cfg_addr < NR_CHANNELS loads mode/duty/period and clears that channel's phase to 0.
  - Visible on outputs 2 cycles after the strobe.
  - cfg_addr >= NR_CHANNELS: write ignored.
- Read:
  - cfg_rd returns cfg_rdata/cfg_rvalid 1 cycle later.
  - Out-of-range address returns 0, with rvalid still pulsing.
  - cfg_rdata holds its value until the next read.
- Simultaneous events:
  - Write on the same cycle as a tick: the write wins, phase = 0.
  - restart on the same cycle as a write: the write is applied and all phases are 0.
  - Read on the same cycle as a write to the same channel returns the pre-write contents.
  - cfg_wr and cfg_rd together are both honoured.
- restart:
  - Clears every phase and the prescaler.
  - Config is kept.
  - A ONESHOT channel restarts its shot from phase 0.
- reset asserted mid-pattern returns all state to reset values on the next edge.

Optional Feature:
LED_PATTERN_SHADOW_EN
- Defined:
  - Writes to a channel in mode 2 (PWM) go to shadow duty/period registers, and phase is not cleared.
  - The shadow registers are copied to active on that channel's next phase wrap (tick with phase == period). This gives glitch-free duty changes.
  - Mode field changes still apply immediately.
  - Readback returns the active (not shadow) values.
- Not defined: all writes apply immediately and clear phase as above. No shadow registers are instantiated.

Test Plan:
- Reset check: PRESCALE=4. Hold reset 3 cycles, then release -> led_oe=0, led_out=0, tick first pulses on the 4th cycle after release, then every 4 cycles.
- Write ch0 = {period=3, duty=2, mode=2} -> led_out[0] pattern over ticks is 1,1,0,0 repeating; led_oe[0]=1 two cycles after cfg_wr.
- Duty boundaries, ch1 mode=2, period=3: duty=0 -> led_out[1] constantly 0; duty=5 -> constantly 1.
- ONESHOT: ch2 = {period=2, duty=1, mode=3} -> out high 1 tick, low 2 ticks; oneshot_done[2] pulses once; then led_oe[2]=0; readback of ch2 shows mode=0.
- restart mid-pattern on ch0 at phase 2 -> phase reads 0 and prescaler restarts; cfg for ch0 is unchanged on readback.
- Write to cfg_addr=NR_CHANNELS -> no channel changes; cfg_rd of that address gives cfg_rdata=0 and cfg_rvalid=1. With LED_PATTERN_SHADOW_EN, a duty change from 1 to 3 at phase 1 takes effect only after the phase wrap.
